// File: rtl/parallel_to_serial_if.sv
// parallel_to_serial_if: handshake bundle for the parallel-to-serial converter.
//   parallel_valid/parallel_data/parallel_ready : word channel (source -> block)
//   serial_valid/serial_data/serial_last/serial_ready : bit channel (block -> sink)
// master = the side that feeds words and consumes bits (source/sink),
// slave  = the converter itself.
interface parallel_to_serial_if #(
    parameter int unsigned width = 8
);
    logic             parallel_valid;
    logic [width-1:0] parallel_data;
    logic             parallel_ready;
    logic             serial_valid;
    logic             serial_data;
    logic             serial_last;
    logic             serial_ready;

    modport master (
        output parallel_valid, parallel_data, serial_ready,
        input  parallel_ready, serial_valid, serial_data, serial_last
    );

    modport slave (
        input  parallel_valid, parallel_data, serial_ready,
        output parallel_ready, serial_valid, serial_data, serial_last
    );
endinterface

// File: rtl/parallel_to_serial.sv
// parallel_to_serial: converts width-bit words into an LSB-first serial stream.
// A one-word holding buffer behind the shifter lets the next word be handed
// over while the current one shifts out, giving gapless back-to-back output.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (drops in-flight and buffered words)
//   bus   : parallel_to_serial_if.slave (word input channel, bit output channel)
module parallel_to_serial #(
    parameter int unsigned width = 8
) (
    input logic               clk,
    input logic               rst_n,
    parallel_to_serial_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(width);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(width - 1);

    logic [width-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [width-1:0] buf_q, buf_d;
    logic             buf_full_q, buf_full_d;

    logic accept;
    logic last;
    logic xfer;
    logic done;

    assign bus.parallel_ready = !buf_full_q;
    assign bus.serial_valid   = busy_q;
    assign bus.serial_data    = busy_q & shift_q[0];
    assign bus.serial_last    = last;

    assign accept = bus.parallel_valid && !buf_full_q;
    assign last   = busy_q && (cnt_q == LAST_CNT);
    assign xfer   = busy_q && bus.serial_ready;
    assign done   = xfer && last;

    always_comb begin
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;

        if (!busy_q) begin
            if (accept) begin
                shift_d = bus.parallel_data;
                cnt_d   = '0;
                busy_d  = 1'b1;
            end
        end else if (done) begin
            // Word finished: reload from the buffer first, otherwise take the
            // incoming word straight into the shifter so no idle cycle appears.
            if (buf_full_q) begin
                shift_d    = buf_q;
                cnt_d      = '0;
                buf_full_d = 1'b0;
            end else if (accept) begin
                shift_d = bus.parallel_data;
                cnt_d   = '0;
            end else begin
                busy_d = 1'b0;
            end
        end else if (xfer) begin
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 1'b1;
        end

        // Only a word arriving mid-shift parks in the buffer; buf_full_q blocks
        // accept, so a refill never coincides with a drain.
        if (accept && busy_q && !done) begin
            buf_d      = bus.parallel_data;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
        end
    end
endmodule

// File: tb/tb_parallel_to_serial.sv
// Scoreboard bench for parallel_to_serial (width = 8).
module tb_parallel_to_serial;
    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;

    parallel_to_serial_if #(.width(W)) bus ();

    parallel_to_serial #(.width(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned last_cnt = 0;
    int unsigned last_cyc = 0;
    int unsigned prev_last_cyc = 0;

    // Expected bit stream: {last, data}
    logic [1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every presented bit against the head of the queue;
    // stalled bits are compared without popping so they must stay stable.
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.serial_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_bit", 32'd1, 32'd0);
                end else begin
                    e = exp_q[0];
                    check("serial_data", {31'd0, bus.serial_data}, {31'd0, e[0]});
                    check("serial_last", {31'd0, bus.serial_last}, {31'd0, e[1]});
                    if (bus.serial_ready) begin
                        void'(exp_q.pop_front());
                        if (e[1]) begin
                            last_cnt++;
                            prev_last_cyc = last_cyc;
                            last_cyc = cyc;
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word; called just after a rising edge. Returns just after the
    // accepting edge with parallel_valid dropped.
    task automatic send(input logic [W-1:0] w);
        bit ok;
        ok = 1'b0;
        bus.parallel_valid = 1'b1;
        bus.parallel_data  = w;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.parallel_ready) begin
                for (int b = 0; b < int'(W); b++)
                    exp_q.push_back({(b == int'(W) - 1), w[b]});
                ok = 1'b1;
            end
            step();
            if (ok) break;
        end
        bus.parallel_valid = 1'b0;
        if (!ok) check("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.serial_valid) break;
        end
        check("drain_queue_empty", exp_q.size(), 32'd0);
        check("drain_idle", {31'd0, bus.serial_valid}, 32'd0);
        step();
    endtask

    int unsigned base;

    initial begin
        rst_n = 1'b0;
        bus.parallel_valid = 1'b1;
        bus.parallel_data  = 8'hAA;
        bus.serial_ready   = 1'b1;

        // Reset: inputs ignored, outputs at reset values
        repeat (3) begin
            @(negedge clk);
            check("rst_valid", {31'd0, bus.serial_valid}, 32'd0);
            check("rst_data", {31'd0, bus.serial_data}, 32'd0);
            check("rst_last", {31'd0, bus.serial_last}, 32'd0);
            check("rst_ready", {31'd0, bus.parallel_ready}, 32'd1);
        end
        step();
        rst_n = 1'b1;
        send(8'hAA);
        check("first_clk_accept", {31'd0, bus.serial_valid}, 32'd1);
        drain();

        // Single word A5: valid for 8 cycles, last only on the 8th
        send(8'hA5);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("a5_valid", {31'd0, bus.serial_valid}, (i < 8) ? 32'd1 : 32'd0);
            check("a5_last", {31'd0, bus.serial_last}, (i == 7) ? 32'd1 : 32'd0);
        end
        step();
        drain();

        // Back-to-back 01, 80 with gapless output
        base = last_cnt;
        send(8'h01);
        send(8'h80);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("b2b_pready", {31'd0, bus.parallel_ready}, (i == 7) ? 32'd1 : 32'd0);
            check("b2b_valid", {31'd0, bus.serial_valid}, 32'd1);
        end
        step();
        drain();
        check("b2b_last_count", last_cnt - base, 32'd2);
        check("b2b_last_spacing", last_cyc - prev_last_cyc, 32'd8);

        // Backpressure F0 with serial_ready alternating 0,1
        bus.serial_ready = 1'b0;
        send(8'hF0);
        for (int c = 0; c < 16; c++) begin
            bus.serial_ready = c[0];
            @(negedge clk);
            check("bp_valid", {31'd0, bus.serial_valid}, 32'd1);
            step();
        end
        check("bp_done16", {31'd0, bus.serial_valid}, 32'd0);
        bus.serial_ready = 1'b1;
        drain();

        // Full stall with three words
        bus.serial_ready = 1'b0;
        send(8'h11);
        send(8'h22);
        bus.parallel_valid = 1'b1;
        bus.parallel_data  = 8'h33;
        repeat (5) begin
            @(negedge clk);
            check("stall_pready", {31'd0, bus.parallel_ready}, 32'd0);
            step();
        end
        bus.serial_ready = 1'b1;
        send(8'h33);
        drain();

        // Reset mid-word: FF shifting, 0F buffered
        send(8'hFF);
        send(8'h0F);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, bus.serial_valid}, 32'd0);
        check("midrst_pready", {31'd0, bus.parallel_ready}, 32'd1);
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        send(8'h3C);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
